// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared FSM state type and default sizing for the SIPO block controller
//
// Purpose : common definitions imported by the controller, its shift buffer,
//           its bus interface and the testbench.
// Contents: SIPO_WIDTH_DEFAULT / SIPO_DEPTH_DEFAULT - word width and words per
//           block (64 x 17 = 1088-bit SHAKE256 rate block);
//           sipo_state_t - controller states FILL, PAD, HOLD;
//           cnt_bits()   - width of a counter that must hold 0..depth.
package sipo_ctrl_pkg;

   localparam int SIPO_WIDTH_DEFAULT = 64;
   localparam int SIPO_DEPTH_DEFAULT = 17;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_PAD  = 2'd1,
      ST_HOLD = 2'd2
   } sipo_state_t;

   // A word count runs 0..depth inclusive, so it needs room for depth+1 values.
   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sipo_block_ctrl_if.sv
// rtl/sipo_block_ctrl_if.sv - word-in / block-out handshake bundle of the SIPO block controller
//
// Purpose : groups the input word handshake and the output block handshake.
// Signals : in_valid/in_ready/in_data/in_last  - word stream into the block
//           blk_valid/blk_ready                - assembled block handshake
//           blk_data  [DEPTH*WIDTH]            - assembled block, first word in top slot
//           blk_last                           - block holds the final message word
//           blk_words [cnt_bits(DEPTH)]        - real (non-pad) words in the block
// Modports: slave  - the controller's view
//           master - the producer/consumer view
interface sipo_block_ctrl_if
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH_DEFAULT,
   parameter int DEPTH = SIPO_DEPTH_DEFAULT
) ();

   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            in_data;
   logic                        in_last;
   logic                        blk_valid;
   logic                        blk_ready;
   logic [DEPTH*WIDTH-1:0]      blk_data;
   logic                        blk_last;
   logic [cnt_bits(DEPTH)-1:0]  blk_words;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  blk_ready,
      output in_ready,
      output blk_valid,
      output blk_data,
      output blk_last,
      output blk_words
   );

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output blk_ready,
      input  in_ready,
      input  blk_valid,
      input  blk_data,
      input  blk_last,
      input  blk_words
   );

endinterface

// File: rtl/sipo_buffer.sv
// rtl/sipo_buffer.sv - serial-in parallel-out word shift register
//
// Purpose : shifts one WIDTH-bit word in at the bottom whenever en is high;
//           after DEPTH shifts the oldest word sits in the top slot.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-high reset, clears the register
//           en       - shift enable
//           data_in  [WIDTH]        - word shifted into the lowest slot
//           data_out [DEPTH*WIDTH]  - full register contents
module sipo_buffer
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH_DEFAULT,
   parameter int DEPTH = SIPO_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [WIDTH-1:0]       data_in,
   output logic [DEPTH*WIDTH-1:0] data_out
);

   logic [DEPTH*WIDTH-1:0] shreg_q;

   generate
      if (DEPTH > 1) begin : g_multi
         // Older words move up one slot; the new word lands in the bottom slot.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shreg_q <= '0;
            end else if (en) begin
               shreg_q <= {shreg_q[(DEPTH-1)*WIDTH-1:0], data_in};
            end
         end
      end else begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shreg_q <= '0;
            end else if (en) begin
               shreg_q <= data_in;
            end
         end
      end
   endgenerate

   assign data_out = shreg_q;

endmodule

// File: rtl/sipo_block_ctrl.sv
// rtl/sipo_block_ctrl.sv - assembles a word stream into fixed-size zero-padded blocks
//
// Purpose : accepts WIDTH-bit words until DEPTH have arrived or the message
//           ends; a short final block is topped up with zero words, then the
//           block is held on blk_data until the consumer takes it.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset; discards any partial block
//           bus - sipo_block_ctrl_if.slave (word input and block output handshakes)
// States  : FILL - accept words (in_ready=1)
//           PAD  - shift one zero word per cycle until the block is full
//           HOLD - present the block (blk_valid=1) until blk_ready
module sipo_block_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH_DEFAULT,
   parameter int DEPTH = SIPO_DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   sipo_block_ctrl_if.slave bus
);

   localparam int            CW       = cnt_bits(DEPTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   sipo_state_t      state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    words_q, words_d;
   logic             last_q, last_d;
   logic [CW-1:0]    cnt_inc;
   logic             shift_en;
   logic [WIDTH-1:0] shift_data;

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         words_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         words_q <= words_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      words_d       = words_q;
      last_d        = last_q;
      shift_en      = 1'b0;
      shift_data    = bus.in_data;
      bus.in_ready  = 1'b0;
      bus.blk_valid = 1'b0;

      case (state_q)
         ST_FILL: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               shift_en = 1'b1;
               cnt_d    = cnt_inc;
               if (bus.in_last) begin
                  last_d = 1'b1;
               end
               // A full block goes straight to HOLD even when in_last is also
               // set; only a short final block needs padding.
               if (cnt_inc == CNT_FULL) begin
                  state_d = ST_HOLD;
                  words_d = cnt_inc;
               end else if (bus.in_last) begin
                  state_d = ST_PAD;
                  words_d = cnt_inc;
               end
            end
         end

         ST_PAD: begin
            // words_q already holds the real-word count; cnt keeps running so
            // the pad stops exactly when the register is full.
            shift_en   = 1'b1;
            shift_data = '0;
            cnt_d      = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            bus.blk_valid = 1'b1;
            if (bus.blk_ready) begin
               state_d = ST_FILL;
               cnt_d   = '0;
               words_d = '0;
               last_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   sipo_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_sipo_buffer (
      .clk      (clk),
      .rst      (rst),
      .en       (shift_en),
      .data_in  (shift_data),
      .data_out (bus.blk_data)
   );

   assign bus.blk_last  = last_q;
   assign bus.blk_words = words_q;

endmodule

// File: doc/sipo_block_ctrl.md
SIPO_BLOCK_CTRL -- requirements
Module: sipo_block_ctrl

Interface
REQ-001 Parameter WIDTH, default 64, is the word width in bits.
REQ-002 Parameter DEPTH, default 17, is the words per block (SHAKE256 rate, 1088 bits).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data and in_last are valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  input word.
REQ-008 in_last  input  1  the word is the final word of the message; qualified by in_valid.
REQ-009 blk_valid  output  1  an assembled block is presented.
REQ-010 blk_ready  input  1  the consumer takes the block.
REQ-011 blk_data  output  DEPTH*WIDTH  assembled block.
REQ-012 blk_last  output  1  the block contains the final message word.
REQ-013 blk_words  output  $clog2(DEPTH+1)  count of real (non-pad) words in the block, 1..DEPTH.

Function
REQ-014 The block SHALL implement FSM states FILL, PAD and HOLD, with FILL entered after reset.
REQ-015 An input handshake SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in FILL.
REQ-016 Each input handshake SHALL shift in_data into the SIPO and increment word counter cnt.
REQ-017 FILL->HOLD SHALL occur on the handshake that brings cnt to DEPTH, regardless of in_last.
REQ-018 FILL->PAD SHALL occur on a handshake with in_last=1 and resulting cnt < DEPTH.
REQ-019 PAD SHALL shift one all-zero word per cycle, without accepting input, until the total is DEPTH, then enter HOLD.
REQ-020 The padding latency SHALL be exactly DEPTH-n cycles for n real words.
REQ-021 The SIPO SHALL NOT shift in HOLD, so blk_data SHALL be stable while blk_valid=1.
REQ-022 In HOLD, blk_valid SHALL be 1; HOLD->FILL SHALL occur on blk_ready, with cnt, blk_last and blk_words cleared next cycle.
REQ-023 After DEPTH shifts, the first accepted word SHALL occupy blk_data[DEPTH*WIDTH-1 -: WIDTH], and each later word the next lower slot.
REQ-024 Padding words SHALL occupy the lowest DEPTH-n slots.
REQ-025 A flag latched on the in_last handshake SHALL drive blk_last, which SHALL hold through HOLD.
REQ-026 blk_words SHALL equal the real-word count latched at the PAD/HOLD transition.
REQ-027 Minimum block period SHALL be DEPTH+1 cycles, with one bubble after each HOLD exit.
REQ-028 blk_ready outside HOLD SHALL be ignored.
REQ-029 in_valid outside FILL SHALL be ignored, and no word SHALL be lost.
REQ-030 cnt SHALL never exceed DEPTH.

Reset
REQ-031 On rst, the block SHALL enter FILL with cnt=0 and the SIPO cleared to zero.
REQ-032 During and after reset, in_ready=1 (FILL), blk_valid=0, blk_last=0, blk_words=0 and blk_data=0.
REQ-033 Reset asserted mid-FILL, mid-PAD or mid-HOLD SHALL discard the partial block with no output handshake.

Structure
REQ-034 Shared package sipo_ctrl_pkg SHALL hold the FSM state enum and the default WIDTH/DEPTH constants.
REQ-035 The block SHALL instantiate one sipo_buffer (WIDTH, DEPTH) as its sub-module.
REQ-036 Its en SHALL be driven by the controller (handshake in FILL, 1 in PAD, 0 in HOLD), with data_in muxed to zero in PAD.
REQ-037 Counter, FSM and flags SHALL live in sipo_block_ctrl.

Verification
REQ-038 Full block: 17 words 0x1..0x11, in_last on word 17 -> HOLD next cycle, blk_words=17, blk_last=1, top slot 0x1, bottom slot 0x11.
REQ-039 Short message: 5 words 0xA..0xE, in_last on word 5 -> 12 PAD cycles, then blk_words=5, top five slots 0xA..0xE, low 12 slots 0, in_ready=0 throughout PAD.
REQ-040 Backpressure: hold blk_ready=0 for 10 cycles in HOLD with in_valid=1 -> blk_data unchanged, in_ready=0, no input consumed; blk_ready=1 -> FILL and in_ready=1 next cycle.
REQ-041 Multi-block: 34 words, in_last on word 34 -> first block blk_last=0, blk_words=17; second block blk_last=1, blk_words=17.
REQ-042 Reset mid-PAD after 3 words -> all outputs 0, in_ready=1; the next 17-word message produces a clean block with no residue.
REQ-043 Random in_valid/blk_ready gaps over 100 messages of length 1..40 -> scoreboard match, and no accepted word dropped or duplicated.
